inst_cache: RTL and testbench

- Direct-mapped, read-only instruction cache that answers the program counter's fetch requests.
- Takes the 16-bit instruction address from the PC and returns the instruction word together with `hit`.
- The PC advances only when `hit` is 1. On a miss, the cache refills a 4-word line from main memory over a req/ready handshake while holding `hit` at 0, which stalls the PC.

---
 rtl/inst_cache.sv | 140 ++++++++++++++
 tb/tb_inst_cache.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache.
//   clk, rst          : clock, asynchronous active-high reset
//   instAddr          : word fetch address from the PC
//   hit, instruction  : lookup result, valid in IDLE only
//   memReq, memAddr   : refill request and word address to main memory
//   memData, memReady : refill data and its valid strobe
// Optional INST_CACHE_STATS_EN adds hitCount/missCount outputs.
module inst_cache #(
  parameter int unsigned INDEX_BITS  = 5,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instAddr,
  output logic        hit,
  output logic [15:0] instruction,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic [15:0] memData,
  input  logic        memReady
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
`endif
);

  localparam int unsigned TAG_BITS = 16 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                 state_q, state_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tagArr [LINES];
  logic [15:0]            dataArr [LINES][WORDS];
  logic [TAG_BITS-1:0]    refTag_q, refTag_d;
  logic [INDEX_BITS-1:0]  refIdx_q, refIdx_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [15:0]            memAddr_q, memAddr_d;

  logic [TAG_BITS-1:0]    reqTag;
  logic [INDEX_BITS-1:0]  reqIdx;
  logic [OFFSET_BITS-1:0] reqOff;
  logic                   lookupHit;
  logic                   startRefill;
  logic                   acceptWord;
  logic                   lastWord;

  assign reqTag = instAddr[15 -: TAG_BITS];
  assign reqIdx = instAddr[OFFSET_BITS +: INDEX_BITS];
  assign reqOff = instAddr[0 +: OFFSET_BITS];

  assign lookupHit   = (state_q == IDLE) && valid_q[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign hit         = lookupHit;
  assign instruction = lookupHit ? dataArr[reqIdx][reqOff] : '0;
  assign memReq      = (state_q == REFILL);
  assign memAddr     = memAddr_q;

  always_comb begin
    state_d     = state_q;
    refTag_d    = refTag_q;
    refIdx_d    = refIdx_q;
    cnt_d       = cnt_q;
    memAddr_d   = memAddr_q;
    startRefill = 1'b0;
    acceptWord  = 1'b0;
    lastWord    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lookupHit) begin
          startRefill = 1'b1;
          refTag_d    = reqTag;
          refIdx_d    = reqIdx;
          cnt_d       = '0;
          memAddr_d   = {reqTag, reqIdx, {OFFSET_BITS{1'b0}}};
          state_d     = REFILL;
        end
      end
      REFILL: begin
        if (memReady) begin
          acceptWord = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          memAddr_d  = memAddr_q + 16'd1;
          if (cnt_q == '1) begin
            lastWord = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bit drops at refill entry so an interrupted refill never leaves a usable line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      refTag_q  <= '0;
      refIdx_q  <= '0;
      cnt_q     <= '0;
      memAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      refTag_q  <= refTag_d;
      refIdx_q  <= refIdx_d;
      cnt_q     <= cnt_d;
      memAddr_q <= memAddr_d;
      if (startRefill) valid_q[reqIdx] <= 1'b0;
      if (lastWord)    valid_q[refIdx_q] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset.
  always_ff @(posedge clk) begin
    if (acceptWord) dataArr[refIdx_q][cnt_q] <= memData;
    if (lastWord)   tagArr[refIdx_q] <= refTag_q;
  end

`ifdef INST_CACHE_STATS_EN
  logic [15:0] hitCount_q, missCount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (lookupHit)   hitCount_q  <= hitCount_q + 16'd1;
      if (startRefill) missCount_q <= missCount_q + 16'd1;
    end
  end

  assign hitCount  = hitCount_q;
  assign missCount = missCount_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hits, conflict miss, slow memory,
// reset mid-refill, and (with INST_CACHE_STATS_EN) the hit/miss counters.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic [15:0] instAddr;
  logic        hit;
  logic [15:0] instruction;
  logic        memReq;
  logic [15:0] memAddr;
  logic [15:0] memData;
  logic        memReady;
  logic [15:0] base;
`ifdef INST_CACHE_STATS_EN
  logic [15:0] hitCount;
  logic [15:0] missCount;
`endif

  int unsigned passed;
  int unsigned total;

  inst_cache #(.INDEX_BITS(5), .OFFSET_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .instAddr   (instAddr),
    .hit        (hit),
    .instruction(instruction),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memData    (memData),
    .memReady   (memReady)
`ifdef INST_CACHE_STATS_EN
    ,
    .hitCount   (hitCount),
    .missCount  (missCount)
`endif
  );

  // Memory model: each line's word k holds base + k.
  assign memData = base + {14'h0, memAddr[1:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    instAddr = 16'h0040;
    memReady = 1'b0;
    base     = 16'hA000;

    // Reset state
    step();
    chk("rst_memReq", {15'h0, memReq}, 16'h0000);
    chk("rst_memAddr", memAddr, 16'h0000);
    chk("rst_hit", {15'h0, hit}, 16'h0000);
`ifdef INST_CACHE_STATS_EN
    chk("rst_hitCount", hitCount, 16'h0000);
    chk("rst_missCount", missCount, 16'h0000);
`endif
    step();
    rst = 1'b0;

    // Cold miss on 0x0040, memory always ready
    memReady = 1'b1;
    #1;
    chk("cold_miss_hit", {15'h0, hit}, 16'h0000);
    chk("cold_miss_instr", instruction, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cold_memReq", {15'h0, memReq}, 16'h0001);
      chk("cold_memAddr", memAddr, 16'h0040 + 16'(i));
      chk("cold_refill_hit", {15'h0, hit}, 16'h0000);
    end
    step();
    chk("cold_done_hit", {15'h0, hit}, 16'h0001);
    chk("cold_done_instr", instruction, 16'hA000);
    chk("cold_done_memReq", {15'h0, memReq}, 16'h0000);

    // Hits across the filled line; memReady stays high and must be ignored
    step();
    for (int i = 1; i < 4; i++) begin
      instAddr = 16'h0040 + 16'(i);
      #1;
      chk("line_hit", {15'h0, hit}, 16'h0001);
      chk("line_instr", instruction, 16'hA000 + 16'(i));
      chk("line_memReq", {15'h0, memReq}, 16'h0000);
      step();
    end
`ifdef INST_CACHE_STATS_EN
    chk("stats_missCount", missCount, 16'h0001);
    chk("stats_hitCount", hitCount, 16'h0004);
`endif

    // Conflict miss: 0x0840 shares index 16 with 0x0040
    instAddr = 16'h0840;
    base     = 16'hB000;
    #1;
    chk("conf_miss_hit", {15'h0, hit}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("conf_memAddr", memAddr, 16'h0840 + 16'(i));
      chk("conf_memReq", {15'h0, memReq}, 16'h0001);
    end
    step();
    chk("conf_done_hit", {15'h0, hit}, 16'h0001);
    chk("conf_done_instr", instruction, 16'hB000);
    instAddr = 16'h0040;
    base     = 16'hA000;
    #1;
    chk("conf_reaccess_miss", {15'h0, hit}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reacc_memAddr", memAddr, 16'h0040 + 16'(i));
    end
    step();
    chk("reacc_done_hit", {15'h0, hit}, 16'h0001);
    chk("reacc_done_instr", instruction, 16'hA000);

    // Slow memory: memReady high only every 3rd cycle
    instAddr = 16'h0100;
    base     = 16'hC000;
    memReady = 1'b0;
    #1;
    chk("slow_miss_hit", {15'h0, hit}, 16'h0000);
    step();
    for (int w = 0; w < 4; w++) begin
      chk("slow_addr_a", memAddr, 16'h0100 + 16'(w));
      step();
      chk("slow_addr_b", memAddr, 16'h0100 + 16'(w));
      chk("slow_memReq", {15'h0, memReq}, 16'h0001);
      step();
      memReady = 1'b1;
      chk("slow_addr_c", memAddr, 16'h0100 + 16'(w));
      chk("slow_wait_hit", {15'h0, hit}, 16'h0000);
      step();
      memReady = 1'b0;
    end
    #1;
    chk("slow_done_hit", {15'h0, hit}, 16'h0001);
    chk("slow_done_instr", instruction, 16'hC000);
    instAddr = 16'h0103;
    #1;
    chk("slow_last_instr", instruction, 16'hC003);

    // Reset after two words of a refill of 0x0200
    step();
    instAddr = 16'h0200;
    base     = 16'hD000;
    memReady = 1'b1;
    step();
    chk("mid_memAddr0", memAddr, 16'h0200);
    step();
    step();
    chk("mid_memAddr2", memAddr, 16'h0202);
    rst = 1'b1;
    #1;
    chk("mid_rst_memReq", {15'h0, memReq}, 16'h0000);
    chk("mid_rst_memAddr", memAddr, 16'h0000);
    step();
    rst = 1'b0;
    #1;
    chk("mid_after_miss", {15'h0, hit}, 16'h0000);
    instAddr = 16'h0040;
    #1;
    chk("mid_old_line_invalid", {15'h0, hit}, 16'h0000);
    instAddr = 16'h0103;
    #1;
    chk("mid_slow_line_invalid", {15'h0, hit}, 16'h0000);
    instAddr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_refill_memAddr", memAddr, 16'h0200 + 16'(i));
      chk("mid_refill_memReq", {15'h0, memReq}, 16'h0001);
    end
    step();
    chk("mid_done_hit", {15'h0, hit}, 16'h0001);
    chk("mid_done_instr", instruction, 16'hD000);
    instAddr = 16'h0203;
    #1;
    chk("mid_done_instr3", instruction, 16'hD003);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
